// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control sequencer with memory handshake timeout
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       br_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_fetch,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BAD
    } cls_t;

    state_t           st;
    cls_t             cls;
    cls_t             dec_cls;
    logic [CNT_W-1:0] cnt;
    logic             cnt_limit;
    logic             store_done;

    logic       mem_req_q, mem_we_q, mem_is_fetch_q, pc_we_q, reg_we_q;
    logic       alu_src_q, retire_q, illegal_q, timeout_q;
    logic [1:0] pc_sel_q, wb_sel_q, alu_op_q;

    // Instruction class decode from the opcode held in IR
    always_comb begin
        dec_cls = C_BAD;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            default:    dec_cls = C_BAD;
        endcase
    end

    // {alu_op, alu_src} used while executing an instruction of class c
    function automatic logic [2:0] alu_cfg(input cls_t c);
        case (c)
            C_R:     return 3'b00_0;
            C_I:     return 3'b10_1;
            C_BR:    return 3'b11_0;
            C_JAL:   return 3'b01_0;
            default: return 3'b01_1;
        endcase
    endfunction

    // The request would hit the timeout limit on this cycle unless memory answers now
    assign cnt_limit = (cnt == CNT_W'(TIMEOUT_CYCLES - 2)) && !mem_ready;

    // Sequencer: state, instruction class, timeout counter and registered per-state outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= S_FETCH;
            cls            <= C_BAD;
            cnt            <= '0;
            mem_req_q      <= 1'b1;
            mem_is_fetch_q <= 1'b1;
            mem_we_q       <= 1'b0;
            pc_we_q        <= 1'b0;
            pc_sel_q       <= 2'b00;
            reg_we_q       <= 1'b0;
            wb_sel_q       <= 2'b00;
            alu_src_q      <= 1'b0;
            alu_op_q       <= 2'b01;
            retire_q       <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            mem_req_q      <= 1'b0;
            mem_is_fetch_q <= 1'b0;
            mem_we_q       <= 1'b0;
            pc_we_q        <= 1'b0;
            pc_sel_q       <= 2'b00;
            reg_we_q       <= 1'b0;
            wb_sel_q       <= 2'b00;
            alu_src_q      <= 1'b0;
            alu_op_q       <= 2'b01;
            retire_q       <= 1'b0;
            if (mem_ready) begin
                cnt <= '0;
            end else if (mem_req_q) begin
                cnt <= cnt + 1'b1;
            end
            case (st)
                S_FETCH: begin
                    if (mem_ready) begin
                        st <= S_DECODE;
                    end else if (cnt_limit) begin
                        st        <= S_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        mem_req_q      <= 1'b1;
                        mem_is_fetch_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    cls <= dec_cls;
                    if (dec_cls == C_BAD) begin
                        st        <= S_HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        st                  <= S_EXEC;
                        {alu_op_q, alu_src_q} <= alu_cfg(dec_cls);
                        if (dec_cls == C_BR) begin
                            pc_we_q  <= 1'b1;
                            retire_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (cls == C_BR) begin
                        st             <= S_FETCH;
                        mem_req_q      <= 1'b1;
                        mem_is_fetch_q <= 1'b1;
                        cnt            <= '0;
                    end else if (cls == C_LOAD || cls == C_STORE) begin
                        st        <= S_MEM;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (cls == C_STORE);
                        alu_src_q <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        st       <= S_WB;
                        reg_we_q <= 1'b1;
                        pc_we_q  <= 1'b1;
                        retire_q <= 1'b1;
                        wb_sel_q <= (cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00;
                        pc_sel_q <= (cls == C_JAL) ? 2'b01 : (cls == C_JALR) ? 2'b10 : 2'b00;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (cls == C_STORE) begin
                            st             <= S_FETCH;
                            mem_req_q      <= 1'b1;
                            mem_is_fetch_q <= 1'b1;
                        end else begin
                            st       <= S_WB;
                            reg_we_q <= 1'b1;
                            pc_we_q  <= 1'b1;
                            retire_q <= 1'b1;
                            wb_sel_q <= 2'b01;
                        end
                    end else if (cnt_limit) begin
                        st        <= S_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (cls == C_STORE);
                        alu_src_q <= 1'b1;
                    end
                end
                S_WB: begin
                    st             <= S_FETCH;
                    mem_req_q      <= 1'b1;
                    mem_is_fetch_q <= 1'b1;
                    cnt            <= '0;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_HALT;
            endcase
        end
    end

    // Handshake-qualified strobes complete in the same cycle memory answers
    assign store_done   = (st == S_MEM) && (cls == C_STORE) && mem_ready;
    assign ir_we        = (st == S_FETCH) && mem_ready && !rst;
    assign pc_we        = pc_we_q | store_done;
    assign retire       = retire_q | store_done;
    assign pc_sel       = (st == S_EXEC && cls == C_BR) ? {1'b0, br_taken} : pc_sel_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_is_fetch = mem_is_fetch_q;
    assign reg_we       = reg_we_q;
    assign wb_sel       = wb_sel_q;
    assign alu_src      = alu_src_q;
    assign alu_op       = alu_op_q;
    assign illegal      = illegal_q;
    assign timeout      = timeout_q;
    assign state        = st;

endmodule
